branch_predictor_f: RTL

Fetch-stage dynamic branch-direction predictor. It holds a table of 2-bit saturating counters indexed by fetch PC and produces the taken prediction for conditional branches in F. It registers that prediction into the F/D boundary as the decode-stage "took branch" flag. It retrains each counter from the decode-stage branch resolution (mispredict/PCSrc) produced downstream in D.

---
 rtl/branch_predictor_f_if.sv | 25 ++
 rtl/branch_predictor_f.sv | 96 +++++++++
 2 files changed

// File: rtl/branch_predictor_f_if.sv
// Fetch/decode signal bundle for the branch-direction predictor.
interface branch_predictor_f_if #(
    parameter int unsigned STAT_W = 32
);
    logic [31:0]       iPCF;
    logic              iIsBranchF;
    logic              iStallD;
    logic              iFlushD;
    logic              iBranchD;
    logic              iPCSrcD;
    logic              oTakeJBF;
    logic              oTakeJBD;
    logic [STAT_W-1:0] oBranchCount;
    logic [STAT_W-1:0] oMispredictCount;

    modport master (
        output iPCF, iIsBranchF, iStallD, iFlushD, iBranchD, iPCSrcD,
        input  oTakeJBF, oTakeJBD, oBranchCount, oMispredictCount
    );

    modport slave (
        input  iPCF, iIsBranchF, iStallD, iFlushD, iBranchD, iPCSrcD,
        output oTakeJBF, oTakeJBD, oBranchCount, oMispredictCount
    );
endinterface

// File: rtl/branch_predictor_f.sv
// Fetch-stage 2-bit saturating-counter branch predictor, trained from the
// decode-stage resolution of the branch carried across the F/D boundary.
module branch_predictor_f #(
    parameter int unsigned INDEX_BITS = 6,
    parameter logic [1:0]  CNT_INIT   = 2'b01,
    parameter int unsigned STAT_W     = 32
) (
    input logic           iClk,
    input logic           iRstN,
    branch_predictor_f_if.slave bus
);
    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            table_q [ENTRIES];
    logic [1:0]            table_d [ENTRIES];
    logic                  fd_take_q,  fd_take_d;
    logic                  fd_valid_q, fd_valid_d;
    logic [INDEX_BITS-1:0] fd_idx_q,   fd_idx_d;
    logic [STAT_W-1:0]     branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0]     mispred_cnt_q, mispred_cnt_d;

    logic [INDEX_BITS-1:0] idx_f;
    logic                  take_f;
    logic                  train;
    logic                  actual;
    logic [1:0]            cnt_cur;
    logic [1:0]            cnt_nxt;
    logic                  unused_pc;

    // Word-aligned PC bits select the counter; the rest are ignored.
    assign idx_f     = bus.iPCF[INDEX_BITS+1:2];
    assign unused_pc = ^{bus.iPCF[31:INDEX_BITS+2], bus.iPCF[1:0]};
    assign take_f    = bus.iIsBranchF & table_q[idx_f][1];

    assign bus.oTakeJBF         = take_f;
    assign bus.oTakeJBD         = fd_take_q;
    assign bus.oBranchCount     = branch_cnt_q;
    assign bus.oMispredictCount = mispred_cnt_q;

    // Training uses current D contents, so a concurrent flush does not cancel it.
    assign train   = fd_valid_q & bus.iBranchD & ~bus.iStallD;
    assign actual  = fd_take_q ^ bus.iPCSrcD;
    assign cnt_cur = table_q[fd_idx_q];

    always_comb begin
        cnt_nxt = cnt_cur;
        if (actual) begin
            if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'd1;
        end
    end

    always_comb begin
        table_d       = table_q;
        fd_take_d     = fd_take_q;
        fd_valid_d    = fd_valid_q;
        fd_idx_d      = fd_idx_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (train) begin
            table_d[fd_idx_q] = cnt_nxt;
            if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + STAT_W'(1);
            if (bus.iPCSrcD && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
        end

        if (bus.iFlushD) begin
            fd_take_d  = 1'b0;
            fd_valid_d = 1'b0;
            fd_idx_d   = '0;
        end else if (!bus.iStallD) begin
            fd_take_d  = take_f;
            fd_valid_d = 1'b1;
            fd_idx_d   = idx_f;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int unsigned i = 0; i < ENTRIES; i++) table_q[i] <= CNT_INIT;
            fd_take_q     <= 1'b0;
            fd_valid_q    <= 1'b0;
            fd_idx_q      <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            table_q       <= table_d;
            fd_take_q     <= fd_take_d;
            fd_valid_q    <= fd_valid_d;
            fd_idx_q      <= fd_idx_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
endmodule
